vector_dot_sequencer: RTL

Control stage that sits directly in front of block_ram and drives its single port. On start it reads two vectors, A and B, stored in RAM, multiplies them element by element and accumulates a dot product. It drives the RAM address and write-enable, and consumes the RAM's registered one-cycle read data. The final sum is presented with a one-cycle done pulse. Reads alternate A[i] and B[i] because the RAM has one port.

---
 rtl/vector_dot_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/vector_dot_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : vector_dot_sequencer
// Description : Drives a single-port block_ram to fetch A[i] and B[i]
//               alternately and accumulates their unsigned dot product.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_dot_sequencer #(
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 18,
    parameter int ACC_WIDTH  = 34
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_a,
    input  logic [ADDR_WIDTH-1:0] base_b,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_write_enable,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  busy,
    output logic                  done,
    output logic [ACC_WIDTH-1:0]  result
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH_A = 3'd1,
        S_FETCH_B = 3'd2,
        S_LAST    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                r_state,   w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr,    w_addr_next;
    logic [ADDR_WIDTH-1:0] r_base_a,  w_base_a_next;
    logic [ADDR_WIDTH-1:0] r_base_b,  w_base_b_next;
    logic [LEN_WIDTH-1:0]  r_len,     w_len_next;
    logic [LEN_WIDTH-1:0]  r_idx,     w_idx_next;
    logic [DATA_WIDTH-1:0] r_a,       w_a_next;
    logic [ACC_WIDTH-1:0]  r_acc,     w_acc_next;
    logic                  r_pending, w_pending_next;
    logic [ACC_WIDTH-1:0]  r_result,  w_result_next;

    logic [2*DATA_WIDTH-1:0] w_prod;
    logic [ADDR_WIDTH-1:0]   w_idx_addr;
    logic [ACC_WIDTH-1:0]    w_acc_sum;

    assign w_prod     = r_a * ram_rd_data;
    assign w_idx_addr = ADDR_WIDTH'(r_idx);
    assign w_acc_sum  = r_acc + ACC_WIDTH'(w_prod);

    always_comb begin
        w_state_next   = r_state;
        w_addr_next    = r_addr;
        w_base_a_next  = r_base_a;
        w_base_b_next  = r_base_b;
        w_len_next     = r_len;
        w_idx_next     = r_idx;
        w_a_next       = r_a;
        w_acc_next     = r_acc;
        w_pending_next = r_pending;
        w_result_next  = r_result;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_base_a_next = base_a;
                    w_base_b_next = base_b;
                    w_len_next    = length;
                    w_acc_next    = '0;
                    if (length != '0) begin
                        w_idx_next     = '0;
                        w_pending_next = 1'b0;
                        w_addr_next    = base_a;
                        w_state_next   = S_FETCH_A;
                    end else begin
                        w_result_next = '0;
                        w_state_next  = S_DONE;
                    end
                end
            end
            S_FETCH_A: begin
                // Read data here is B[idx-1], paired with the A held in r_a
                if (r_pending) begin
                    w_acc_next = w_acc_sum;
                end
                w_addr_next  = r_base_b + w_idx_addr;
                w_state_next = S_FETCH_B;
            end
            S_FETCH_B: begin
                w_a_next       = ram_rd_data;
                w_pending_next = 1'b1;
                if (r_idx == r_len - LEN_WIDTH'(1)) begin
                    w_state_next = S_LAST;
                end else begin
                    w_idx_next   = r_idx + LEN_WIDTH'(1);
                    w_addr_next  = r_base_a + w_idx_addr + ADDR_WIDTH'(1);
                    w_state_next = S_FETCH_A;
                end
            end
            S_LAST: begin
                w_acc_next    = w_acc_sum;
                w_result_next = w_acc_sum;
                w_state_next  = S_DONE;
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_base_a  <= '0;
            r_base_b  <= '0;
            r_len     <= '0;
            r_idx     <= '0;
            r_a       <= '0;
            r_acc     <= '0;
            r_pending <= 1'b0;
            r_result  <= '0;
        end else begin
            r_state   <= w_state_next;
            r_addr    <= w_addr_next;
            r_base_a  <= w_base_a_next;
            r_base_b  <= w_base_b_next;
            r_len     <= w_len_next;
            r_idx     <= w_idx_next;
            r_a       <= w_a_next;
            r_acc     <= w_acc_next;
            r_pending <= w_pending_next;
            r_result  <= w_result_next;
        end
    end

    assign ram_addr         = r_addr;
    assign ram_write_enable = 1'b0;
    assign ram_data_in      = '0;
    assign busy             = (r_state != S_IDLE);
    assign done             = (r_state == S_DONE);
    assign result           = r_result;

endmodule
`default_nettype wire
